reorder_buffer_mp: RTL

Parametrised multi-port reorder buffer, the successor to the single-port ROB. It sits between dispatch, the common data bus (CDB) and the register file. It allocates one entry per dispatched instruction and accepts results from `CDB_PORTS` functional-unit buses in the same cycle. It provides two tag-lookup ports with CDB bypass for operand fetch, retires in order through a valid/ready commit handshake, and performs full recovery when a mispredicted branch commits.

---
 rtl/reorder_buffer_mp.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer_mp.sv
// Multi-port reorder buffer: in-order allocate/commit, CDB_PORTS completion buses,
// two bypassed tag-lookup ports and full flush when a mispredicted branch commits.
module reorder_buffer_mp #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 32,
   parameter int CDB_PORTS = 3,
   parameter int TAG_W     = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [4:0]                 enq_rd,
   input  logic                       enq_has_rd,
   input  logic [WIDTH-1:0]           enq_pc,
   output logic [TAG_W-1:0]           enq_tag,
   input  logic [CDB_PORTS-1:0]       cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
   input  logic [CDB_PORTS*WIDTH-1:0] cdb_data,
   input  logic [CDB_PORTS-1:0]       cdb_mispredict,
   input  logic [2*TAG_W-1:0]         lk_tag,
   output logic [1:0]                 lk_rdy,
   output logic [2*WIDTH-1:0]         lk_data,
   output logic                       commit_valid,
   input  logic                       commit_ready,
   output logic [TAG_W-1:0]           commit_tag,
   output logic [4:0]                 commit_rd,
   output logic                       commit_has_rd,
   output logic [WIDTH-1:0]           commit_data,
   output logic [WIDTH-1:0]           commit_pc,
   output logic                       flush,
   output logic [TAG_W:0]             count
);
   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]     valid_q, valid_d, done_q, done_d, mis_q, mis_d, has_rd_q, has_rd_d;
   logic [4:0]           rd_q   [DEPTH];
   logic [4:0]           rd_d   [DEPTH];
   logic [WIDTH-1:0]     pc_q   [DEPTH];
   logic [WIDTH-1:0]     pc_d   [DEPTH];
   logic [WIDTH-1:0]     data_q [DEPTH];
   logic [WIDTH-1:0]     data_d [DEPTH];
   logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]       count_q, count_d;
   logic                 enq_fire_s, commit_fire_s;
   logic [CDB_PORTS-1:0] cdb_hit_s;

   assign commit_valid  = valid_q[head_q] & done_q[head_q];
   assign commit_fire_s = commit_valid & commit_ready;
   assign flush         = commit_fire_s & mis_q[head_q];
   assign enq_ready     = (count_q != FULL) & ~flush;
   assign enq_fire_s    = enq_valid & enq_ready;
   assign enq_tag       = tail_q;
   assign commit_tag    = head_q;
   assign commit_rd     = rd_q[head_q];
   assign commit_has_rd = has_rd_q[head_q];
   assign commit_data   = data_q[head_q];
   assign commit_pc     = pc_q[head_q];
   assign count         = count_q;

   // A CDB write only takes effect on an allocated, not-yet-done entry, and never during flush
   always_comb begin
      cdb_hit_s = '0;
      for (int i = 0; i < CDB_PORTS; i++) begin
         cdb_hit_s[i] = cdb_valid[i] & valid_q[cdb_tag[i*TAG_W +: TAG_W]]
                        & ~done_q[cdb_tag[i*TAG_W +: TAG_W]] & ~flush;
      end
   end

   // Lookup: storage first, then CDB bypass with the highest port index winning
   always_comb begin
      lk_rdy  = '0;
      lk_data = '0;
      for (int j = 0; j < 2; j++) begin
         lk_rdy[j] = valid_q[lk_tag[j*TAG_W +: TAG_W]] & done_q[lk_tag[j*TAG_W +: TAG_W]];
         lk_data[j*WIDTH +: WIDTH] = data_q[lk_tag[j*TAG_W +: TAG_W]];
         for (int i = 0; i < CDB_PORTS; i++) begin
            lk_rdy[j] = lk_rdy[j] |
                        (cdb_hit_s[i] & (cdb_tag[i*TAG_W +: TAG_W] == lk_tag[j*TAG_W +: TAG_W]));
            lk_data[j*WIDTH +: WIDTH] =
               (cdb_hit_s[i] && (cdb_tag[i*TAG_W +: TAG_W] == lk_tag[j*TAG_W +: TAG_W]))
               ? cdb_data[i*WIDTH +: WIDTH] : lk_data[j*WIDTH +: WIDTH];
         end
      end
   end

   // Next state: completion, commit clear, allocation, then flush overrides everything
   always_comb begin
      valid_d  = valid_q;
      done_d   = done_q;
      mis_d    = mis_q;
      has_rd_d = has_rd_q;
      rd_d     = rd_q;
      pc_d     = pc_q;
      data_d   = data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      for (int i = 0; i < CDB_PORTS; i++) begin
         done_d[cdb_tag[i*TAG_W +: TAG_W]] = cdb_hit_s[i] | done_d[cdb_tag[i*TAG_W +: TAG_W]];
         data_d[cdb_tag[i*TAG_W +: TAG_W]] = cdb_hit_s[i] ? cdb_data[i*WIDTH +: WIDTH]
                                                          : data_d[cdb_tag[i*TAG_W +: TAG_W]];
         mis_d[cdb_tag[i*TAG_W +: TAG_W]]  = cdb_hit_s[i] ? cdb_mispredict[i]
                                                          : mis_d[cdb_tag[i*TAG_W +: TAG_W]];
      end
      if (commit_fire_s) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         mis_d[head_q]   = 1'b0;
         head_d          = head_q + 1'b1;
      end else begin
         head_d = head_q;
      end
      if (enq_fire_s) begin
         valid_d[tail_q]  = 1'b1;
         done_d[tail_q]   = 1'b0;
         mis_d[tail_q]    = 1'b0;
         has_rd_d[tail_q] = enq_has_rd;
         rd_d[tail_q]     = enq_rd;
         pc_d[tail_q]     = enq_pc;
         tail_d           = tail_q + 1'b1;
      end else begin
         tail_d = tail_q;
      end
      if (flush) begin
         valid_d = '0;
         done_d  = '0;
         mis_d   = '0;
         head_d  = head_q + 1'b1;
         tail_d  = head_q + 1'b1;
         count_d = '0;
      end else begin
         count_d = count_q + {{TAG_W{1'b0}}, enq_fire_s} - {{TAG_W{1'b0}}, commit_fire_s};
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         done_q   <= '0;
         mis_q    <= '0;
         has_rd_q <= '0;
         rd_q     <= '{default: '0};
         pc_q     <= '{default: '0};
         data_q   <= '{default: '0};
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         done_q   <= done_d;
         mis_q    <= mis_d;
         has_rd_q <= has_rd_d;
         rd_q     <= rd_d;
         pc_q     <= pc_d;
         data_q   <= data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
      end
   end
endmodule
